// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the E stage: runs a fixed-latency busy window per op
// and owns the HI/LO registers, committing the precomputed result when the window ends.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES) > 4) ? $clog2(MAX_CYCLES) : 4;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       thi, tlo;
    logic              is_mult, is_div, accept, commit, mt_hi, mt_lo;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               neg_a, neg_b;
    logic [31:0]        mag_a, mag_b, divisor, q_mag, r_mag;
    logic [31:0]        res_hi, res_lo;

    assign busy = (state == BUSY);

    always_comb begin
        is_mult    = (op == 4'd1) || (op == 4'd2);
        is_div     = (op == 4'd3) || (op == 4'd4);
        accept     = 1'b0;
        commit     = 1'b0;
        mt_hi      = 1'b0;
        mt_lo      = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (!cancel) begin
                    if (start && (is_mult || is_div)) begin
                        accept     = 1'b1;
                        state_next = BUSY;
                    end
                    mt_hi = (op == 4'd5);
                    mt_lo = (op == 4'd6);
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Division on magnitudes avoids the 0x80000000 / -1 overflow corner.
    always_comb begin
        prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u  = {32'd0, A} * {32'd0, B};
        neg_a   = (op == 4'd3) && A[31];
        neg_b   = (op == 4'd3) && B[31];
        mag_a   = neg_a ? -A : A;
        mag_b   = neg_b ? -B : B;
        divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;
        q_mag   = mag_a / divisor;
        r_mag   = mag_a % divisor;
        if (is_mult) begin
            {res_hi, res_lo} = (op == 4'd1) ? prod_s : prod_u;
        end else if (B == 32'd0) begin
            res_hi = hi;
            res_lo = lo;
        end else begin
            res_hi = neg_a ? -r_mag : r_mag;
            res_lo = (neg_a ^ neg_b) ? -q_mag : q_mag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            thi  <= '0;
            tlo  <= '0;
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= commit;
            if (accept) begin
                thi <= res_hi;
                tlo <= res_lo;
                cnt <= is_mult ? MULT_LOAD : DIV_LOAD;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                hi <= thi;
                lo <= tlo;
            end else begin
                if (mt_hi) hi <= A;
                if (mt_lo) lo <= A;
            end
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed vector table, hand-written corner sequences and random ops
// checked against an arithmetic reference model of HI/LO.
module tb_mdu_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        cancel = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;
    vec_t vecs[8];

    always @(posedge clk)
        if (reset && busy && (start || op == 4'd5 || op == 4'd6))
            $error("FAIL req_while_busy: request seen while busy");

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] ch,
                                               input logic [31:0] cl);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint          q, r;
        longint unsigned uq, ur;
        case (o)
            4'd1: return sa * sb;
            4'd2: return ua * ub;
            4'd3: begin
                if (b == 32'd0) return {ch, cl};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return {ch, cl};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return {ch, cl};
        endcase
    endfunction

    task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int en);
        int n;
        start = 1'b1; op = o; A = a; B = b;
        step();
        start = 1'b0; op = 4'd0;
        n = 0;
        while (busy && n < 64) begin
            chk({nm, "_hold"}, {hi, lo}, {m_hi, m_lo});
            n++;
            step();
        end
        chk({nm, "_busy_len"}, 64'(n), 64'(en));
        chk({nm, "_done"}, 64'(done), 64'd1);
        chk({nm, "_hilo"}, {hi, lo}, {eh, el});
        m_hi = eh;
        m_lo = el;
        step();
        chk({nm, "_done_clr"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        logic [63:0] r;
        logic [3:0]  o;
        logic [31:0] a, b;

        vecs[0] = '{4'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, MC};
        vecs[1] = '{4'd4, 32'd7,        32'd2,        32'd1,        32'd3,        DC};
        vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[3] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DC};
        vecs[4] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
        vecs[5] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DC};
        vecs[6] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        MC};
        vecs[7] = '{4'd4, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, DC};

        #3;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        step();
        reset = 1'b1;
        step();

        foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                                 vecs[i].hi, vecs[i].lo, vecs[i].n);

        // Cancelled mult leaves everything untouched.
        start = 1'b1; op = 4'd1; A = 32'd3; B = 32'd4; cancel = 1'b1;
        step();
        start = 1'b0; op = 4'd0; cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        step();
        chk("cancel_done", 64'(done), 64'd0);
        chk("cancel_hilo", {hi, lo}, {m_hi, m_lo});

        // mthi/mtlo then divide by zero keeps HI/LO.
        op = 4'd5; A = 32'h1234;
        step();
        op = 4'd6; A = 32'h5678;
        step();
        op = 4'd0;
        m_hi = 32'h1234; m_lo = 32'h5678;
        chk("mthi_mtlo", {hi, lo}, {32'h1234, 32'h5678});
        chk("mt_busy", 64'(busy), 64'd0);
        run_op("div_zero", 4'd3, 32'd5, 32'd0, 32'h1234, 32'h5678, DC);

        // Back-to-back: divu accepted in the multu done cycle.
        start = 1'b1; op = 4'd2; A = 32'hFFFFFFFF; B = 32'd2;
        step();
        start = 1'b0; op = 4'd0;
        n = 0;
        while (busy && n < 64) begin n++; step(); end
        chk("b2b_mult_len", 64'(n), 64'(MC));
        chk("b2b_mult_done", 64'(done), 64'd1);
        chk("b2b_mult_hilo", {hi, lo}, {32'd1, 32'hFFFFFFFE});
        start = 1'b1; op = 4'd4; A = 32'd7; B = 32'd2;
        step();
        start = 1'b0; op = 4'd0;
        chk("b2b_reaccept", 64'(busy), 64'd1);
        chk("b2b_hold", {hi, lo}, {32'd1, 32'hFFFFFFFE});
        n = 0;
        while (busy && n < 64) begin n++; step(); end
        chk("b2b_div_len", 64'(n), 64'(DC));
        chk("b2b_div_hilo", {hi, lo}, {32'd1, 32'd3});
        m_hi = 32'd1; m_lo = 32'd3;
        step();

        // Random ops against the reference model.
        for (int k = 0; k < 60; k++) begin
            o = 4'($urandom_range(1, 6));
            case ($urandom_range(0, 3))
                0: a = 32'h80000000;
                1: a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'(signed'($urandom_range(0, 20)) - 10);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) begin
                start = (o <= 4'd4); op = o; A = a; B = b; cancel = 1'b1;
                step();
                start = 1'b0; op = 4'd0; cancel = 1'b0;
                chk("rnd_cancel_busy", 64'(busy), 64'd0);
                chk("rnd_cancel_hilo", {hi, lo}, {m_hi, m_lo});
                step();
                chk("rnd_cancel_done", 64'(done), 64'd0);
            end else if (o <= 4'd4) begin
                r = ref_result(o, a, b, m_hi, m_lo);
                run_op($sformatf("rnd%0d_op%0d", k, o), o, a, b, r[63:32], r[31:0],
                       (o <= 4'd2) ? MC : DC);
            end else begin
                op = o; A = a; start = 1'($urandom_range(0, 1));
                step();
                op = 4'd0; start = 1'b0;
                if (o == 4'd5) m_hi = a;
                else           m_lo = a;
                chk("rnd_mt_hilo", {hi, lo}, {m_hi, m_lo});
                chk("rnd_mt_busy", 64'(busy), 64'd0);
            end
        end

        // Reset during the third busy cycle of a div aborts with no commit.
        start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd7;
        step();
        start = 1'b0; op = 4'd0;
        step();
        step();
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        step();
        reset = 1'b1;
        n = 0;
        for (int k = 0; k < DC + 2; k++) begin
            step();
            if (done || busy) n++;
        end
        chk("abort_no_pulse", 64'(n), 64'd0);
        chk("abort_hilo_after", {hi, lo}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
